// File: rtl/alu_pkg.sv
// Shared widths, skid-buffer state encoding and the per-beat flag bundle
// for the shift result stage.
package alu_pkg;
    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic lost;
    } flags_t;
endpackage

// File: rtl/shift_lost_detect.sv
// Reports whether a left shift of a by shift pushes any 1-bit out of the word.
module shift_lost_detect
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHIFT_W-1:0] shift,
    output logic               lost
);
    always_comb begin
        lost = 1'b0;
        if (shift == '0)
            lost = 1'b0;
        else if (shift >= SHIFT_W'(DATA_W))
            lost = |a;
        else
            // Bits that fall off the top are the top 'shift' bits of a.
            lost = |(a >> (SHIFT_W'(DATA_W) - shift));
    end
endmodule

// File: rtl/alu_shift_result_stage.sv
// Registers the shifter result and its flags behind a 2-entry skid buffer.
// Define ALU_SHIFT_LOST_FLAG_EN to enable the shifted-out-ones flag.
module alu_shift_result_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [DATA_W-1:0]  asl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               flag_lost,
    output logic [15:0]        xfer_count
);
    skid_state_t       state, state_next;
    logic [DATA_W-1:0] out_data, skid_data;
    flags_t            out_flags, skid_flags, in_flags;
    logic              accept, emit;
    logic              load_out_in, load_out_skid, load_skid;

    assign in_flags.zero = (asl == '0);
    assign in_flags.neg  = asl[DATA_W-1];

`ifdef ALU_SHIFT_LOST_FLAG_EN
    shift_lost_detect u_lost (
        .a     (a),
        .shift (shift),
        .lost  (in_flags.lost)
    );
`else
    // Lost bit tied low, so its stored copy is a constant and folds away.
    assign in_flags.lost = 1'b0;
    logic unused_operands;
    assign unused_operands = ^{a, shift};
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next  = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                case ({accept, emit})
                    2'b10: begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end
                    2'b01:   state_next  = EMPTY;
                    2'b11:   load_out_in = 1'b1;
                    default: state_next  = ONE;
                endcase
            end
            FULL: begin
                if (emit) begin
                    state_next    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_data   <= '0;
            out_flags  <= '0;
            skid_data  <= '0;
            skid_flags <= '0;
            xfer_count <= '0;
        end else begin
            state    <= state_next;
            // Registered so out_ready never reaches in_ready combinationally.
            in_ready <= (state_next != FULL);
            if (load_out_in) begin
                out_data  <= asl;
                out_flags <= in_flags;
            end else if (load_out_skid) begin
                out_data  <= skid_data;
                out_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_data  <= asl;
                skid_flags <= in_flags;
            end
            if (emit)
                xfer_count <= xfer_count + 16'd1;
        end
    end

    assign result    = out_data;
    assign flag_zero = out_flags.zero;
    assign flag_neg  = out_flags.neg;
    assign flag_lost = out_flags.lost;
endmodule

// File: tb/tb_alu_shift_result_stage.sv
// Scoreboard bench for alu_shift_result_stage: directed beats push expected
// results; a negedge monitor pops and compares every emitted beat.
module tb_alu_shift_result_stage;
`ifdef ALU_SHIFT_LOST_FLAG_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  a = 8'h00, asl = 8'h00;
    logic [3:0]  shift = 4'h0;
    logic        in_ready, out_valid, flag_zero, flag_neg, flag_lost;
    logic [7:0]  result;
    logic [15:0] xfer_count;

    alu_shift_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .shift(shift), .asl(asl), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_zero(flag_zero),
        .flag_neg(flag_neg), .flag_lost(flag_lost), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       z, n, l;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0;

    // Hand-computed vectors: a, shift, asl, zero, neg, lost (lost with flag enabled)
    logic [7:0] va [7] = '{8'h81, 8'h00, 8'h40, 8'h5A, 8'h01, 8'hF0, 8'h0F};
    logic [3:0] vs [7] = '{4'd1,  4'd5,  4'd1,  4'd0,  4'd12, 4'd4,  4'd4};
    logic [7:0] vq [7] = '{8'h02, 8'h00, 8'h80, 8'h5A, 8'h00, 8'h00, 8'hF0};
    logic       vz [7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic       vn [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic       vl [7] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("flag_zero", {31'd0, flag_zero}, {31'd0, e.z});
                chk("flag_neg", {31'd0, flag_neg}, {31'd0, e.n});
                chk("flag_lost", {31'd0, flag_lost}, {31'd0, e.l});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] ta, input logic [3:0] ts, input logic [7:0] tasl,
                        input logic z, input logic n, input logic l);
        exp_t e;
        bit   done = 1'b0;
        a = ta; shift = ts; asl = tasl; in_valid = 1'b1;
        e.res = tasl; e.z = z; e.n = n; e.l = LOST_EN ? l : 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("drain_empty", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, flag_zero, flag_neg, flag_lost}, 32'd0);
        chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_rise", {31'd0, in_ready}, 32'd1);

        // One-cycle latency from EMPTY, then hold while stalled.
        send(va[0], vs[0], vq[0], vz[0], vn[0], vl[0]);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_result", {24'd0, result}, 32'h02);
        repeat (2) begin @(posedge clk); #1; end
        chk("stall_result", {24'd0, result}, 32'h02);
        chk("stall_lost", {31'd0, flag_lost}, {31'd0, LOST_EN});
        out_ready = 1'b1;
        for (int i = 1; i < 7; i++) send(va[i], vs[i], vq[i], vz[i], vn[i], vl[i]);
        drain();
        chk("xfer_after_vectors", {16'd0, xfer_count}, 32'd7);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_hold_result", {24'd0, result}, 32'hF0);
        chk("idle_hold_neg", {31'd0, flag_neg}, 32'd1);

        // Backpressure: two beats fill the buffer, the third is refused.
        out_ready = 1'b0;
        send(8'h11, 4'd1, 8'h22, 1'b0, 1'b0, 1'b0);
        send(8'h90, 4'd2, 8'h40, 1'b0, 1'b0, 1'b1);
        a = 8'h03; shift = 4'd3; asl = 8'h18; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_head", {24'd0, result}, 32'h22);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'h03, 4'd3, 8'h18, 1'b0, 1'b0, 1'b0);
        drain();
        chk("xfer_after_full", {16'd0, xfer_count}, 32'd10);

        // Counter wrap.
        for (int i = 0; i < 65525; i++) send(8'h00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drain();
        chk("xfer_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
        send(8'h00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drain();
        chk("xfer_wrap", {16'd0, xfer_count}, 32'd0);

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        send(8'h22, 4'd1, 8'h44, 1'b0, 1'b0, 1'b0);
        send(8'h33, 4'd1, 8'h66, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_xfer", {16'd0, xfer_count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_no_beat", {31'd0, out_valid}, 32'd0);
        chk("post_rst_xfer", {16'd0, xfer_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
